pipe_skid_stage: RTL

Parametrised elastic pipeline stage that replaces the fixed, stall-only inter-stage registers between EX, MEM and WB. It carries a payload and a control field with a valid/ready handshake. A 2-entry skid buffer keeps full throughput while cutting the combinational path from downstream ready to upstream ready. Flush squashes in-flight entries and inserts bubbles, and saturating counters report back-pressure and squashed entries.

---
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic valid/ready pipeline stage with a 2-entry skid buffer.
// The main register drives the outputs. The skid register absorbs the entry that is
// accepted in the first cycle of back-pressure. in_ready is registered, so there is
// no combinational path from out_ready to in_ready. Flush squashes every held entry.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake; in_data / in_ctrl carry the payload
//   flush           synchronous squash of all held entries
//   out_valid/ready downstream handshake; out_data / out_ctrl carry the payload
//                   (out_ctrl reads 0 whenever out_valid = 0)
//   occupancy       number of entries held (0..2)
//   stall_cnt       saturating count of cycles with out_valid=1 and out_ready=0
//   drop_cnt        saturating count of valid entries discarded by flush
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned SUM_W = CNT_W + 1;

  // Encoding equals the occupancy of each state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state;
  state_e              state_nxt;
  logic [DATA_W-1:0]   skid_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic                in_fire;
  logic                out_fire;
  logic [1:0]          drop_inc;
  logic [SUM_W-1:0]    drop_sum;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_fire) state_nxt = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_nxt = FULL;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      FULL:    if (out_fire) state_nxt = BUSY;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Entries lost to a flush: everything held minus the one leaving, plus the one arriving.
  always_comb begin
    drop_inc = occupancy + 2'(in_fire) - 2'(out_fire);
    drop_sum = {1'b0, drop_cnt} + SUM_W'(drop_inc);
  end

  // State, payload registers and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= 2'(state_nxt);

      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        out_ctrl <= '0;
        drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              out_data <= in_data;
              out_ctrl <= in_ctrl;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              out_data <= in_data;
              out_ctrl <= in_ctrl;
            end else if (in_fire) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
            end else if (out_fire) begin
              // Main drains: present a NOP, keep the stale payload.
              out_ctrl <= '0;
            end
          end
          FULL: begin
            if (out_fire) begin
              out_data <= skid_data;
              out_ctrl <= skid_ctrl;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
